// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Structural half_adder cell and the full_adder built from two of them.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out,
  output logic s
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),    .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(c_in), .s(s),  .c(c2));

  assign c_out = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock LSB-first through a registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q;
  // Partial sum keeps only the WIDTH-1 bits already produced; the newest bit comes from the adder.
  logic [WIDTH-2:0]   s_sh_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   sum_q;
  logic               c_out_q;

  logic               fa_s, fa_co;
  logic [WIDTH-1:0]   sum_d;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c_in (carry_q),
    .c_out(fa_co),
    .s    (fa_s)
  );

  assign sum_d = {fa_s, s_sh_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= c_in;
            cnt_q   <= '0;
            state_q <= ST_ADD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADD: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= sum_d[WIDTH-1:1];
          carry_q <= fa_co;
          if (cnt_q == LAST) begin
            sum_q   <= sum_d;
            c_out_q <= fa_co;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == ST_ADD);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with WIDTH=8.
module tb_serial_adder;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands with start, then expect WIDTH busy cycles and a done pulse.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W-1:0] exp_sum, input logic exp_co,
                         input logic [W-1:0] old_sum);
    a = ta; b = tb_; c_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("busy_during_add", {31'd0, busy}, 32'd1);
      chk("done_during_add", {31'd0, done}, 32'd0);
      chk("sum_held",        {24'd0, sum},  {24'd0, old_sum});
      @(negedge clk);
    end
    chk("done_pulse", {31'd0, done},  32'd1);
    chk("busy_low",   {31'd0, busy},  32'd0);
    chk("sum",        {24'd0, sum},   {24'd0, exp_sum});
    chk("c_out",      {31'd0, c_out}, {31'd0, exp_co});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_done",  {31'd0, done},  32'd0);
      chk("rst_sum",   {24'd0, sum},   32'd0);
      chk("rst_c_out", {31'd0, c_out}, 32'd0);
      @(negedge clk);
    end

    run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 8'h00);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("sum_hold_idle",  {24'd0, sum},  32'h7F);

    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h7F);
    @(negedge clk);
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00);
    @(negedge clk);

    // 0x10+0x20 with an ignored mid-ADD start carrying 0xAA+0xAA
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ign_done",  {31'd0, done},  32'd1);
    chk("ign_sum",   {24'd0, sum},   32'h30);
    chk("ign_c_out", {31'd0, c_out}, 32'd0);
    // back-to-back start presented in the DONE cycle
    run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h30);
    @(negedge clk);

    // asynchronous reset in the 3rd ADD cycle
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum",  {24'd0, sum},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h00);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
